imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the instruction memory. It takes a byte stream over a valid/ready handshake, for example from a UART receiver or a debug port. It packs every four bytes into a little-endian 32-bit instruction and writes it through the word-aligned 13-bit byte-address instruction-memory write port. It holds the core in reset while a program image is loading and keeps a running checksum of the loaded words.

Parameters:
DEPTH, 2048, number of 32-bit words in instruction memory; the legal load length is 1..DEPTH.
ADDR_W, 13, byte-address width of the write port; the word index occupies [ADDR_W-1:2].
BOOT_HOLD, 1, 1 = core held in reset from power-up until the first load completes; 0 = core released while idle.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  single-cycle pulse that starts a load
len_i  input  12  number of words to load, sampled on the accepted start
byte_valid_i  input  1  byte_data_i is valid
byte_data_i  input  8  incoming program byte
byte_ready_o  output  1  loader accepts a byte this cycle
wr_en_o  output  1  instruction memory write strobe
wr_addr_o  output  ADDR_W  byte address of the write; always word aligned, [1:0]=0
wr_data_o  output  32  instruction word to write
busy_o  output  1  a load is in progress
done_o  output  1  the last load completed successfully
err_o  output  1  sticky error flag
checksum_o  output  32  modulo-2^32 sum of all words written in the current or last load
cpu_rst_no  output  1  active-low reset to the core

Behaviour:
- Interface decision: one clock, clk_i. Reset rst_ni is asynchronous and active-low. All state is registered on the rising edge of clk_i.
- Reset values: state=IDLE, byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, err_o=0, checksum_o=0.
- cpu_rst_no at reset: 0 if BOOT_HOLD=1, otherwise 1.
- IDLE:
  - start_i with 1<=len_i<=DEPTH: latch len, clear the word counter, byte lane and checksum; clear err_o and done_o; go to RECV.
  - start_i with len_i=0 or len_i>DEPTH: set err_o, stay in IDLE, no write.
- RECV:
  - byte_ready_o=1, busy_o=1, cpu_rst_no=0.
  - A byte is accepted when byte_valid_i and byte_ready_o are both high.
  - The accepted byte goes to lane byte_cnt: the first byte lands in [7:0] and the fourth in [31:24].
  - On the fourth accepted byte, go to WRITE. byte_cnt wraps to 0.
  - byte_valid_i low simply stalls RECV; there is no timeout.
- WRITE (exactly one cycle):
  - wr_en_o=1, wr_addr_o=word_cnt<<2, wr_data_o=assembled word, byte_ready_o=0.
  - checksum_o updates to checksum_o+word, wrapping mod 2^32. word_cnt increments.
  - If this was word len-1, go to DONE; otherwise go back to RECV.
- DONE:
  - done_o=1, busy_o=0, cpu_rst_no=1, byte_ready_o=0.
  - start_i behaves as in IDLE and starts a reload.
  - A reload that fails its length check stays in DONE and only sets err_o.
- wr_en_o is high only in WRITE. wr_addr_o and wr_data_o hold their last values at other times.
- Throughput: at best 5 cycles per word (4 byte accepts plus 1 write cycle).
- Latency: 1 cycle from the fourth byte accept to wr_en_o being high.
- start_i during RECV or WRITE: ignored, err_o set, the load continues undisturbed.
- Bytes offered in IDLE, WRITE or DONE are not accepted because byte_ready_o=0; the source must hold them.
- Reset mid-load: a partial word is discarded with no write. Words already written remain in memory; done_o=0.
- Word address wrap: cannot happen, because len<=DEPTH means the maximum address is (DEPTH-1)*4 = 13'h1FFC.
- Only one outstanding load exists at a time; there is no queueing of starts.

Test Plan:
- Basic load: start_i with len_i=2, then bytes 13,01,30,00,93,02,50,00 with valid held high.
  - Writes at addr 0 data 32'h00300113 and at addr 4 data 32'h00500293; wr_en_o high for exactly 2 cycles.
  - done_o=1, checksum_o=32'h008003A6, cpu_rst_no rises after the second write.
- Stalled source: as the basic load, but byte_valid_i toggles every other cycle.
  - Identical writes and checksum; no byte is lost or duplicated.
- Bad length: start_i with len_i=0, then start_i with len_i=2049.
  - err_o=1 after each, state stays IDLE, no wr_en_o, cpu_rst_no stays 0 (BOOT_HOLD=1).
- Start while busy: start_i pulsed during the second byte of a len_i=1 load.
  - err_o=1, the load still completes with one write at addr 0.
- Reset mid-load: rst_ni asserted after 3 bytes of a word.
  - No wr_en_o pulse, all outputs return to their reset values.
  - A subsequent full load of len_i=1 writes correctly.
- Full depth and reload: len_i=2048 with byte pattern n&8'hFF; the last write goes to addr 13'h1FFC.
  - A reload with len_i=1 resets checksum_o to that single word and drops cpu_rst_no while loading.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the program loader.
// The master is the byte source / memory side; the slave is the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 13
) ();
    logic              byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;

    modport master (
        output byte_valid_i, byte_data_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  byte_valid_i, byte_data_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit instructions, writes them to
// instruction memory and holds the core in reset while a program is loading.
module imem_loader #(
    parameter int DEPTH     = 2048,
    parameter int ADDR_W    = 13,
    parameter int BOOT_HOLD = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [11:0] len_i,
    imem_loader_if.slave bus,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] checksum_o,
    output logic        cpu_rst_no
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

    localparam logic [12:0] DepthW = 13'(DEPTH);

    state_e            state_q, state_d;
    logic [11:0]       len_q, len_d;
    logic [11:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              err_q, err_d;

    logic lenOk, startOk, byteAccept, lastWord, canStart;

    assign lenOk      = (len_i != 12'd0) && ({1'b0, len_i} <= DepthW);
    assign startOk    = start_i && lenOk;
    assign canStart   = (state_q == IDLE) || (state_q == DONE);
    assign byteAccept = bus.byte_valid_i && (state_q == RECV);
    assign lastWord   = (word_cnt_q == len_q - 12'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (startOk) state_d = RECV;
            RECV:       if (byteAccept && byte_cnt_q == 2'd3) state_d = WRITE;
            WRITE:      state_d = lastWord ? DONE : RECV;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready_o = (state_q == RECV);
        bus.wr_en_o      = (state_q == WRITE);
        busy_o           = (state_q == RECV) || (state_q == WRITE);
        done_o           = (state_q == DONE);
        case (state_q)
            IDLE:    cpu_rst_no = (BOOT_HOLD == 0);
            DONE:    cpu_rst_no = 1'b1;
            default: cpu_rst_no = 1'b0;
        endcase
    end

    // The write address/data are captured on the fourth byte so they are ready
    // during WRITE and then simply hold until the next word completes.
    always_comb begin
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        checksum_d = checksum_q;
        err_d      = err_q;

        if (canStart) begin
            if (startOk) begin
                len_d      = len_i;
                word_cnt_d = 12'd0;
                byte_cnt_d = 2'd0;
                checksum_d = 32'd0;
                err_d      = 1'b0;
            end else if (start_i) begin
                err_d = 1'b1;
            end
        end else if (start_i) begin
            err_d = 1'b1;
        end

        if (byteAccept) begin
            asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data_i;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                wr_data_d = {bus.byte_data_i, asm_q[23:0]};
                wr_addr_d = {word_cnt_q[ADDR_W-3:0], 2'b00};
            end
        end

        if (state_q == WRITE) begin
            checksum_d = checksum_q + wr_data_q;
            word_cnt_d = word_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q      <= 12'd0;
            word_cnt_q <= 12'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            checksum_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
        end
    end

    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;
    assign checksum_o    = checksum_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus random byte
// streams compared against a word/checksum model built from the byte list.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [11:0] len_i = 12'd0;
    logic        busy_o, done_o, err_o, cpu_rst_no;
    logic [31:0] checksum_o;

    imem_loader_if #(.ADDR_W(13)) bus ();

    imem_loader #(.DEPTH(2048), .ADDR_W(13), .BOOT_HOLD(1)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .len_i      (len_i),
        .bus        (bus.slave),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .checksum_o (checksum_o),
        .cpu_rst_no (cpu_rst_no)
    );

    always #5 clk_i = ~clk_i;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0]  txBytes[$];
    logic [31:0] expWords[$];
    logic [31:0] expSum;
    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    int  acceptCnt  = 0;
    bit  pending    = 1'b0;
    int  latErr     = 0;
    int  holdViol   = 0;

    // Observes the write port and the handshake: a write must come exactly one
    // cycle after every fourth accepted byte, and the core stays reset while busy.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            acceptCnt = 0;
            pending   = 1'b0;
        end else begin
            if (bus.wr_en_o) begin
                wrAddrQ.push_back(32'(bus.wr_addr_o));
                wrDataQ.push_back(bus.wr_data_o);
                if (!pending) latErr++;
            end else if (pending) begin
                latErr++;
            end
            pending = bus.byte_valid_i && bus.byte_ready_o && (acceptCnt % 4 == 3);
            if (bus.byte_valid_i && bus.byte_ready_o) acceptCnt++;
            if (busy_o && cpu_rst_no) holdViol++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyReset();
        rst_ni = 1'b0;
        bus.byte_valid_i = 1'b0;
        start_i = 1'b0;
        #3;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic buildModel();
        expWords.delete();
        expSum = 32'd0;
        for (int i = 0; i < txBytes.size() / 4; i++) begin
            expWords.push_back({txBytes[4*i+3], txBytes[4*i+2], txBytes[4*i+1], txBytes[4*i]});
            expSum += expWords[i];
        end
    endtask

    task automatic startLoad(input int len);
        wrAddrQ.delete();
        wrDataQ.delete();
        start_i = 1'b1;
        len_i   = 12'(len);
        tick();
        start_i = 1'b0;
    endtask

    // validMode: 0 = always valid, 1 = toggles, 2 = random. startAt pulses
    // start_i while that byte index is on offer (-1 = never).
    task automatic applyStimulus(input int validMode, input int startAt);
        int idx = 0;
        int budget = txBytes.size() * 8 + 100;
        bit phase = 1'b0;
        bit pulsed = 1'b0;
        while (idx < txBytes.size() && budget > 0) begin
            case (validMode)
                0:       bus.byte_valid_i = 1'b1;
                1:       bus.byte_valid_i = phase;
                default: bus.byte_valid_i = 1'($urandom_range(1, 0));
            endcase
            phase = ~phase;
            bus.byte_data_i = txBytes[idx];
            start_i = (idx == startAt) && !pulsed;
            if (start_i) pulsed = 1'b1;
            @(posedge clk_i);
            if (bus.byte_valid_i && bus.byte_ready_o) idx++;
            #1;
            start_i = 1'b0;
            budget--;
        end
        bus.byte_valid_i = 1'b0;
        if (budget == 0) checkOutput("streamTimeout", 32'(idx), 32'(txBytes.size()));
    endtask

    task automatic waitDone();
        int budget = 40;
        while (!done_o && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("doneReached", 32'(done_o), 32'd1);
    endtask

    task automatic checkWrites(input string tag);
        int bad = 0;
        checkOutput({tag, "_count"}, 32'(wrDataQ.size()), 32'(expWords.size()));
        for (int i = 0; i < wrDataQ.size() && i < expWords.size(); i++)
            if (wrDataQ[i] !== expWords[i] || wrAddrQ[i] !== 32'(i * 4)) bad++;
        checkOutput({tag, "_badWords"}, 32'(bad), 32'd0);
        checkOutput({tag, "_checksum"}, checksum_o, expSum);
    endtask

    task automatic loadBasicBytes();
        logic [7:0] basic[8] = '{8'h13, 8'h01, 8'h30, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00};
        txBytes.delete();
        foreach (basic[i]) txBytes.push_back(basic[i]);
        buildModel();
    endtask

    initial begin
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        applyReset();

        checkOutput("rst_ready",    32'(bus.byte_ready_o), 32'd0);
        checkOutput("rst_wrEn",     32'(bus.wr_en_o), 32'd0);
        checkOutput("rst_addr",     32'(bus.wr_addr_o), 32'd0);
        checkOutput("rst_data",     bus.wr_data_o, 32'd0);
        checkOutput("rst_busy",     32'(busy_o), 32'd0);
        checkOutput("rst_done",     32'(done_o), 32'd0);
        checkOutput("rst_err",      32'(err_o), 32'd0);
        checkOutput("rst_checksum", checksum_o, 32'd0);
        checkOutput("rst_cpuRst",   32'(cpu_rst_no), 32'd0);

        // Bad lengths from idle: error only, core kept in reset.
        wrAddrQ.delete();
        startLoad(0);
        checkOutput("len0_err",  32'(err_o), 32'd1);
        checkOutput("len0_busy", 32'(busy_o), 32'd0);
        startLoad(2049);
        tick();
        checkOutput("len2049_err",    32'(err_o), 32'd1);
        checkOutput("len2049_ready",  32'(bus.byte_ready_o), 32'd0);
        checkOutput("len2049_done",   32'(done_o), 32'd0);
        checkOutput("len2049_cpuRst", 32'(cpu_rst_no), 32'd0);
        checkOutput("len2049_writes", 32'(wrDataQ.size()), 32'd0);

        // Basic load with a continuous source.
        loadBasicBytes();
        startLoad(2);
        checkOutput("basic_errCleared", 32'(err_o), 32'd0);
        checkOutput("basic_busy",       32'(busy_o), 32'd1);
        checkOutput("basic_cpuRstLow",  32'(cpu_rst_no), 32'd0);
        applyStimulus(0, -1);
        waitDone();
        checkWrites("basic");
        checkOutput("basic_word0", wrDataQ.size() > 0 ? wrDataQ[0] : 32'hx, 32'h00300113);
        checkOutput("basic_addr1", wrAddrQ.size() > 1 ? wrAddrQ[1] : 32'hx, 32'd4);
        checkOutput("basic_word1", wrDataQ.size() > 1 ? wrDataQ[1] : 32'hx, 32'h00500293);
        checkOutput("basic_sumConst", checksum_o, 32'h008003A6);
        checkOutput("basic_cpuRst", 32'(cpu_rst_no), 32'd1);
        checkOutput("basic_busyEnd", 32'(busy_o), 32'd0);

        // Same image from a source that stalls every other cycle.
        startLoad(2);
        checkOutput("stall_doneCleared", 32'(done_o), 32'd0);
        applyStimulus(1, -1);
        waitDone();
        checkWrites("stall");

        // Random images with a random source.
        for (int t = 0; t < 6; t++) begin
            int len = $urandom_range(6, 1);
            txBytes.delete();
            for (int b = 0; b < len * 4; b++) txBytes.push_back(8'($urandom_range(255, 0)));
            buildModel();
            startLoad(len);
            applyStimulus(2, -1);
            waitDone();
            checkWrites("random");
            checkOutput("random_err", 32'(err_o), 32'd0);
        end

        // Start pulsed while the second byte is on offer.
        txBytes.delete();
        for (int b = 0; b < 4; b++) txBytes.push_back(8'($urandom_range(255, 0)));
        buildModel();
        startLoad(1);
        applyStimulus(0, 1);
        waitDone();
        checkOutput("busyStart_err", 32'(err_o), 32'd1);
        checkWrites("busyStart");

        // Reset after three bytes of a word: nothing is written.
        txBytes.delete();
        for (int b = 0; b < 3; b++) txBytes.push_back(8'($urandom_range(255, 0)));
        startLoad(1);
        applyStimulus(0, -1);
        applyReset();
        checkOutput("midRst_writes",   32'(wrDataQ.size()), 32'd0);
        checkOutput("midRst_done",     32'(done_o), 32'd0);
        checkOutput("midRst_busy",     32'(busy_o), 32'd0);
        checkOutput("midRst_checksum", checksum_o, 32'd0);
        checkOutput("midRst_data",     bus.wr_data_o, 32'd0);
        checkOutput("midRst_cpuRst",   32'(cpu_rst_no), 32'd0);
        txBytes.delete();
        for (int b = 0; b < 4; b++) txBytes.push_back(8'($urandom_range(255, 0)));
        buildModel();
        startLoad(1);
        applyStimulus(0, -1);
        waitDone();
        checkWrites("afterRst");

        // Full-depth image, then a one-word reload.
        txBytes.delete();
        for (int n = 0; n < 2048 * 4; n++) txBytes.push_back(8'(n & 8'hFF));
        buildModel();
        startLoad(2048);
        applyStimulus(0, -1);
        waitDone();
        checkWrites("full");
        checkOutput("full_lastAddr", wrAddrQ.size() > 0 ? wrAddrQ[wrAddrQ.size()-1] : 32'hx, 32'h1FFC);

        txBytes.delete();
        for (int b = 0; b < 4; b++) txBytes.push_back(8'($urandom_range(255, 0)));
        buildModel();
        startLoad(1);
        checkOutput("reload_cpuRstLow", 32'(cpu_rst_no), 32'd0);
        checkOutput("reload_doneLow",   32'(done_o), 32'd0);
        applyStimulus(0, -1);
        waitDone();
        checkWrites("reload");

        // Failed reload from DONE keeps the finished image.
        startLoad(0);
        checkOutput("doneBad_err",  32'(err_o), 32'd1);
        checkOutput("doneBad_done", 32'(done_o), 32'd1);
        checkOutput("doneBad_sum",  checksum_o, expSum);

        checkOutput("writeLatency",  32'(latErr), 32'd0);
        checkOutput("cpuHeldWhileBusy", 32'(holdViol), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
